// File: rtl/gf_arith_unit_if.sv
// rtl/gf_arith_unit_if.sv - command/result handshake bundle for gf_arith_unit
interface gf_arith_unit_if #(parameter int M = 4);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] z;
  logic         busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, z, busy
  );
endinterface

// File: rtl/gf_arith_unit.sv
// rtl/gf_arith_unit.sv - GF(2^M) add, bit-serial multiply and multiply-accumulate
// unit with one command in flight, reduced modulo x^M + POLY.
module gf_arith_unit #(
  parameter int           M    = 4,
  parameter logic [M-1:0] POLY = M'(4'b0011)
) (
  input  logic           clk,
  input  logic           rst,
  gf_arith_unit_if.slave bus
);

  localparam int         CW     = $clog2(M + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MAC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t        state;
  logic [M-1:0]  a_q;
  logic [M-1:0]  b_q;
  logic [M-1:0]  p;
  logic [M-1:0]  p_next;
  logic [M-1:0]  acc;
  logic [M-1:0]  z_q;
  logic          mac_q;
  logic          busy_q;
  logic          out_valid_q;
  logic [CW-1:0] cnt;

  // b_q is shifted left each iteration so its MSB is always the current multiplier bit.
  always_comb begin
    p_next = {p[M-2:0], 1'b0} ^ (p[M-1] ? POLY : '0);
    if (b_q[M-1]) begin
      p_next = p_next ^ a_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      p           <= '0;
      acc         <= '0;
      z_q         <= '0;
      mac_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            mac_q <= (bus.op == OP_MAC);
            case (bus.op)
              OP_ADD: begin
                z_q         <= bus.a ^ bus.b;
                out_valid_q <= 1'b1;
                state       <= DONE;
              end
              OP_CLR: begin
                z_q         <= '0;
                acc         <= '0;
                out_valid_q <= 1'b1;
                state       <= DONE;
              end
              default: begin
                p      <= '0;
                cnt    <= CW'(M - 1);
                busy_q <= 1'b1;
                state  <= MUL;
              end
            endcase
          end
        end
        MUL: begin
          p   <= p_next;
          b_q <= b_q << 1;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
            if (mac_q) begin
              acc <= acc ^ p_next;
              z_q <= acc ^ p_next;
            end else begin
              z_q <= p_next;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gf_arith_unit.sv
// tb/tb_gf_arith_unit.sv - randomized self-checking bench for gf_arith_unit
// (M=4 default polynomial and M=8 with POLY=8'h1B) against a field-arithmetic model.
module tb_gf_arith_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gf_arith_unit_if #(.M(4)) if4 ();
  gf_arith_unit_if #(.M(8)) if8 ();

  gf_arith_unit #(.M(4), .POLY(4'b0011)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  gf_arith_unit #(.M(8), .POLY(8'h1B))   dut8 (.clk(clk), .rst(rst), .bus(if8));

  logic        iv[2];
  logic        ordy[2];
  logic [1:0]  opr[2];
  logic [15:0] ar[2];
  logic [15:0] br[2];
  logic        ir[2];
  logic        ov[2];
  logic        bz[2];
  logic [15:0] zw[2];

  assign if4.in_valid  = iv[0];
  assign if4.op        = opr[0];
  assign if4.a         = ar[0][3:0];
  assign if4.b         = br[0][3:0];
  assign if4.out_ready = ordy[0];
  assign ir[0]         = if4.in_ready;
  assign ov[0]         = if4.out_valid;
  assign bz[0]         = if4.busy;
  assign zw[0]         = {12'h000, if4.z};

  assign if8.in_valid  = iv[1];
  assign if8.op        = opr[1];
  assign if8.a         = ar[1][7:0];
  assign if8.b         = br[1][7:0];
  assign if8.out_ready = ordy[1];
  assign ir[1]         = if8.in_ready;
  assign ov[1]         = if8.out_valid;
  assign bz[1]         = if8.busy;
  assign zw[1]         = {8'h00, if8.z};

  int tests = 0;
  int fails = 0;

  // Expected outcome of the command in flight on each unit.
  bit pend[2];
  bit is_mul[2];
  int exp_z[2];
  int acc_edge[2];
  int lat[2];
  int acc_m[2];
  int ck_k;

  function automatic int mw(input int d);
    return (d != 0) ? 8 : 4;
  endfunction

  function automatic int poly_of(input int d);
    return (d != 0) ? 'h1B : 'h3;
  endfunction

  // Carry-less product followed by long division by x^m + poly.
  function automatic int gf_mul(input int m, input int poly, input int x, input int y);
    int r;
    r = 0;
    for (int i = 0; i < m; i++) begin
      if (((y >> i) & 1) != 0) r = r ^ (x << i);
    end
    for (int i = 2 * m - 2; i >= m; i--) begin
      if (((r >> i) & 1) != 0) r = r ^ (((1 << m) | poly) << (i - m));
    end
    return r;
  endfunction

  task automatic chk(input int d, input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL dut%0d %s: got %0h, required %0h (cycle %0d)", d, name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        chk(d, "in_ready_during_rst", int'(ir[d]), 0);
      end else if (!pend[d]) begin
        chk(d, "out_valid_idle", int'(ov[d]), 0);
        chk(d, "busy_idle", int'(bz[d]), 0);
        chk(d, "in_ready_idle", int'(ir[d]), 1);
      end else begin
        ck_k = cyc - acc_edge[d] + 1;
        chk(d, "in_ready_in_flight", int'(ir[d]), 0);
        if (ck_k < lat[d]) begin
          chk(d, "out_valid_early", int'(ov[d]), 0);
          chk(d, "busy_window", int'(bz[d]), int'(is_mul[d]));
        end else begin
          chk(d, "out_valid_done", int'(ov[d]), 1);
          chk(d, "busy_done", int'(bz[d]), 0);
          chk(d, "z_model", int'(zw[d]), exp_z[d]);
          if (ordy[d]) pend[d] = 1'b0;
        end
      end
    end
  end

  task automatic scramble(input int d);
    iv[d]  = 1'($urandom);
    opr[d] = 2'($urandom);
    ar[d]  = 16'($urandom);
    br[d]  = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pend[d]  = 1'b0;
      acc_m[d] = 0;
      iv[d]    = 1'b0;
      ordy[d]  = 1'b0;
    end
  endtask

  task automatic issue(input int d, input int op, input int a, input int b);
    int m;
    int e;
    int prod;
    bit ok;
    m = mw(d);
    a = a & ((1 << m) - 1);
    b = b & ((1 << m) - 1);
    iv[d]   = 1'b1;
    opr[d]  = 2'(op);
    ar[d]   = 16'(a);
    br[d]   = 16'(b);
    ordy[d] = 1'($urandom);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL dut%0d accept_timeout: in_ready got 0, required 1 within 50 cycles", d);
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    prod = gf_mul(m, poly_of(d), a, b);
    case (op)
      0: e = a ^ b;
      1: e = prod;
      2: begin
        acc_m[d] = acc_m[d] ^ prod;
        e = acc_m[d];
      end
      default: begin
        acc_m[d] = 0;
        e = 0;
      end
    endcase
    exp_z[d]    = e;
    acc_edge[d] = cyc;
    is_mul[d]   = (op == 1) || (op == 2);
    lat[d]      = is_mul[d] ? m + 1 : 1;
    pend[d]     = 1'b1;
    ordy[d]     = 1'b0;
    scramble(d);
  endtask

  task automatic finish_cmd(input int d, input int hold, input int lit);
    bit seen;
    bit done;
    int held;
    seen = 1'b0;
    done = 1'b0;
    held = 0;
    for (int t = 0; t < 60 && !done; t++) begin
      @(negedge clk);
      if (ov[d] && ordy[d]) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        if (ov[d] && !seen) begin
          seen = 1'b1;
          if (lit >= 0) chk(d, "z_literal", int'(zw[d]), lit);
        end
        @(posedge clk);
        #1;
        if (seen) begin
          if (held >= hold) ordy[d] = 1'b1;
          held++;
        end
        scramble(d);
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL dut%0d result_timeout: handshake got none, required within 60 cycles", d);
    end
    iv[d]   = 1'b0;
    ordy[d] = 1'b0;
  endtask

  task automatic run(input int d, input int op, input int a, input int b, input int hold, input int lit);
    issue(d, op, a, b);
    finish_cmd(d, hold, lit);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; opr[d] = 2'b00; ar[d] = '0; br[d] = '0;
      pend[d] = 1'b0; acc_m[d] = 0; is_mul[d] = 1'b0; exp_z[d] = 0; acc_edge[d] = 0; lat[d] = 1;
    end

    chk(0, "model_3x7", gf_mul(4, 'h3, 'h3, 'h7), 'h9);
    chk(0, "model_8x2", gf_mul(4, 'h3, 'h8, 'h2), 'h3);
    chk(0, "model_FxF", gf_mul(4, 'h3, 'hF, 'hF), 'hA);
    chk(1, "model_57x83", gf_mul(8, 'h1B, 'h57, 'h83), 'hC1);

    do_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "reset_z", int'(zw[d]), 0);
      chk(d, "reset_out_valid", int'(ov[d]), 0);
      chk(d, "reset_busy", int'(bz[d]), 0);
      chk(d, "reset_in_ready", int'(ir[d]), 1);
    end
    @(posedge clk);
    #1;

    run(0, 0, 'hA, 'h6, 5, 'hC);
    run(0, 1, 'h3, 'h7, 0, 'h9);
    run(0, 1, 'h8, 'h2, 1, 'h3);
    run(0, 1, 'hF, 'hF, 0, 'hA);
    run(0, 1, 'h5, 'h0, 2, 'h0);

    run(0, 3, 'h7, 'h9, 0, 'h0);
    run(0, 2, 'h3, 'h7, 0, 'h9);
    run(0, 2, 'h8, 'h2, 0, 'hA);
    run(0, 1, 'h2, 'h2, 0, 'h4);
    run(0, 2, 'h1, 'h0, 0, 'hA);

    issue(0, 1, 'h3, 'h7);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    chk(0, "rst_mid_mul_out_valid", int'(ov[0]), 0);
    chk(0, "rst_mid_mul_busy", int'(bz[0]), 0);
    chk(0, "rst_mid_mul_in_ready", int'(ir[0]), 1);
    @(posedge clk);
    #1;
    run(0, 2, 'h1, 'h1, 0, 'h1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run(0, 1, a, b, $urandom_range(0, 1), -1);
      end
    end
    for (int i = 0; i < 100; i++) begin
      run(0, $urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 2), -1);
    end

    run(1, 1, 'h57, 'h83, 0, 'hC1);
    for (int i = 0; i < 300; i++) begin
      run(1, (i % 4 == 3) ? $urandom_range(0, 3) : 1, $urandom, $urandom, $urandom_range(0, 2), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
